// File: rtl/apb_slave_mem_pkg.sv
// Shared types and helpers for the APB3 register-memory completer.
// Holds the FSM state encoding and the address-decode rule.
package apb_pkg;

   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } apb_state_e;

   // Byte address is usable when word-aligned and inside the array.
   function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
   endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between requester and completer.
// Signal names follow the APB3 pin names.
interface apb_slave_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic              PWRITE;
   logic              PSEL;
   logic              PENABLE;
   logic              PREADY;
   logic [DATA_W-1:0] PRDATA;
   logic              PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word store: one synchronous write port, one
// asynchronous read port, whole array cleared by PRESET.
module apb_slave_regfile #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_widx,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_ridx,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // NOTE: the array is cleared on reset because readers rely on all-zero
   // contents afterwards; this forces flops rather than a RAM macro.
   // NOTE: sequential state uses non-blocking (<=) so all flops update
   // together at the edge regardless of statement order.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_widx] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory, with a
// programmable number of wait states and PSLVERR on bad addresses.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = APB_DATA_W,
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic            PCLK,
   input  logic            PRESET,
   apb_slave_mem_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);

   apb_state_e        r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_write;
   logic              r_pready;
   logic [DATA_W-1:0] r_prdata;
   logic              r_pslverr;

   apb_state_e        w_state_nxt;
   logic [3:0]        w_cnt_nxt;
   logic              w_latch;
   logic              w_pready_nxt;
   logic [DATA_W-1:0] w_prdata_nxt;
   logic              w_pslverr_nxt;
   logic              w_setup;
   logic              w_err;
   logic              w_we;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rdata;

   assign w_setup = bus.PSEL && !bus.PENABLE;
   assign w_err   = !addr_ok(64'(r_addr), DEPTH);
   assign w_idx   = r_addr[2 +: IDX_W];
   // Commit happens on the edge that leaves DONE, so a following setup reads it.
   assign w_we    = (r_state == DONE) && r_write && !w_err && !PRESET;

   apb_slave_regfile #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .i_we    (w_we),
      .i_widx  (w_idx),
      .i_wdata (r_wdata),
      .i_ridx  (w_idx),
      .o_rdata (w_rdata)
   );

   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_latch       = 1'b0;
      w_pready_nxt  = 1'b0;
      w_prdata_nxt  = '0;
      w_pslverr_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_setup) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = 4'(WAIT_STATES);
               w_state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!(bus.PSEL && bus.PENABLE)) begin
               w_state_nxt = IDLE;
            end else if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_pready_nxt  = 1'b1;
               w_pslverr_nxt = w_err;
               w_prdata_nxt  = w_err ? '0 : w_rdata;
               w_state_nxt   = DONE;
            end
         end
         DONE: begin
            if (w_setup) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = 4'(WAIT_STATES);
               w_state_nxt = ACCESS;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_write   <= 1'b0;
         r_pready  <= 1'b0;
         r_prdata  <= '0;
         r_pslverr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pready  <= w_pready_nxt;
         r_prdata  <= w_prdata_nxt;
         r_pslverr <= w_pslverr_nxt;
         if (w_latch) begin
            r_addr  <= bus.PADDR;
            r_wdata <= bus.PWDATA;
            r_write <= bus.PWRITE;
         end
      end
   end

   assign bus.PREADY  = r_pready;
   assign bus.PRDATA  = r_prdata;
   assign bus.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 3 wait states) sharing one
// requester; directed table, hand sequences and random traffic vs a model.
module tb_apb_slave_mem;

   logic PCLK = 1'b0;
   logic PRESET;
   always #5 PCLK = ~PCLK;

   logic        sel;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        pready, pslverr;
   logic [31:0] prdata;

   apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
   apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if1 ();

   assign if0.PADDR   = paddr;
   assign if0.PWDATA  = pwdata;
   assign if0.PWRITE  = pwrite;
   assign if0.PENABLE = penable;
   assign if0.PSEL    = psel && !sel;
   assign if1.PADDR   = paddr;
   assign if1.PWDATA  = pwdata;
   assign if1.PWRITE  = pwrite;
   assign if1.PENABLE = penable;
   assign if1.PSEL    = psel && sel;

   assign pready  = sel ? if1.PREADY  : if0.PREADY;
   assign pslverr = sel ? if1.PSLVERR : if0.PSLVERR;
   assign prdata  = sel ? if1.PRDATA  : if0.PRDATA;

   apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
      .PCLK(PCLK), .PRESET(PRESET), .bus(if0));
   apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
      .PCLK(PCLK), .PRESET(PRESET), .bus(if1));

   int n_vec = 0;
   int n_bad = 0;
   int ws [2] = '{0, 3};
   logic [31:0] model_mem [2][64];

   typedef struct {
      bit          sel;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          b2b;
      bit          exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   function automatic bit spec_err(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= 64);
   endfunction

   task automatic clear_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++) model_mem[s][i] = '0;
   endtask

   // One complete transfer; address/data are scrambled in the access phase
   // so only the setup-phase copy may be used by the completer.
   task automatic xfer(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit b2b, output int lat, output bit err,
                       output logic [31:0] rd, output logic drop);
      sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) begin
            penable = 1'b1;
            paddr   = ~a;
            pwdata  = ~d;
         end
      end while (!pready && lat < 40);
      err = pslverr;
      rd  = prdata;
      tick();
      drop = pready;
      if (!b2b) begin
         psel = 1'b0; penable = 1'b0;
      end
   endtask

   task automatic model_write(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d);
      if (w && !spec_err(a)) model_mem[s][a / 4] = d;
   endtask

   initial begin
      int          lat;
      bit          err, saw;
      logic [31:0] rd;
      logic        drop;

      vecs[0]  = '{0, 1, 32'h08,  32'hDEADBEEF, 0, 0, 32'h0};
      vecs[1]  = '{0, 0, 32'h08,  32'h0,        0, 0, 32'hDEADBEEF};
      vecs[2]  = '{1, 1, 32'h3C,  32'h12345678, 0, 0, 32'h0};
      vecs[3]  = '{1, 0, 32'h3C,  32'h0,        0, 0, 32'h12345678};
      vecs[4]  = '{0, 1, 32'h04,  32'hCAFEF00D, 0, 0, 32'h0};
      vecs[5]  = '{0, 1, 32'h100, 32'h11111111, 0, 1, 32'h0};
      vecs[6]  = '{0, 1, 32'h06,  32'h22222222, 0, 1, 32'h0};
      vecs[7]  = '{0, 0, 32'h04,  32'h0,        0, 0, 32'hCAFEF00D};
      vecs[8]  = '{0, 0, 32'hFC,  32'h0,        0, 0, 32'h0};
      vecs[9]  = '{0, 1, 32'h00,  32'h1,        1, 0, 32'h0};
      vecs[10] = '{0, 1, 32'h04,  32'h2,        1, 0, 32'h0};
      vecs[11] = '{0, 0, 32'h00,  32'h0,        1, 0, 32'h1};
      vecs[12] = '{0, 0, 32'h04,  32'h0,        0, 0, 32'h2};

      sel = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
      PRESET = 1'b1;
      clear_model();
      repeat (3) tick();
      PRESET = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check("reset_pready", {31'b0, pready}, 32'h0);
         check("reset_pslverr", {31'b0, pslverr}, 32'h0);
         check("reset_prdata", prdata, 32'h0);
      end

      for (int i = 0; i < 13; i++) begin
         xfer(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].b2b, lat, err, rd, drop);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(2 + ws[vecs[i].sel]));
         check($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
         if (!vecs[i].wr || vecs[i].exp_err)
            check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_pready_1cyc", i), {31'b0, drop}, 32'h0);
         model_write(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      end

      // Reset in the middle of a waited write: transfer dropped, memory cleared.
      xfer(1, 1, 32'h10, 32'h55, 0, lat, err, rd, drop);
      sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'h77;
      tick();
      penable = 1;
      tick();
      PRESET = 1'b1;
      repeat (3) tick();
      check("midreset_pready", {31'b0, pready}, 32'h0);
      check("midreset_pslverr", {31'b0, pslverr}, 32'h0);
      check("midreset_prdata", prdata, 32'h0);
      PRESET = 1'b0; psel = 0; penable = 0;
      clear_model();
      tick();
      xfer(1, 0, 32'h10, 32'h0, 0, lat, err, rd, drop);
      check("midreset_read10", rd, 32'h0);

      // Abort during wait states, then a stray access phase with no setup.
      sel = 1; psel = 1; penable = 0; pwrite = 1; paddr = 32'h20; pwdata = 32'hAA;
      tick();
      penable = 1;
      tick();
      psel = 0; penable = 0;
      saw = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (pready) saw = 1;
      end
      check("abort_no_pready", {31'b0, saw}, 32'h0);
      psel = 1; penable = 1; paddr = 32'h20; pwdata = 32'hBB;
      saw = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (pready) saw = 1;
      end
      check("stray_penable_ignored", {31'b0, saw}, 32'h0);
      psel = 0; penable = 0;
      tick();
      xfer(1, 0, 32'h20, 32'h0, 0, lat, err, rd, drop);
      check("abort_word_unchanged", rd, 32'h0);

      // Random traffic against the array model.
      for (int i = 0; i < 150; i++) begin
         bit          s, w, b2b, e;
         logic [31:0] a, d;
         s   = 1'($urandom_range(0, 1));
         w   = 1'($urandom_range(0, 1));
         b2b = 1'($urandom_range(0, 1));
         d   = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 32'h11F));
         else a = 32'($urandom_range(0, 63)) * 4;
         e = spec_err(a);
         xfer(s, w, a, d, b2b, lat, err, rd, drop);
         check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(2 + ws[s]));
         check($sformatf("rnd%0d_pslverr", i), {31'b0, err}, {31'b0, e});
         if (!w || e)
            check($sformatf("rnd%0d_prdata", i), rd, (e || w) ? 32'h0 : model_mem[s][a / 4]);
         check($sformatf("rnd%0d_pready_1cyc", i), {31'b0, drop}, 32'h0);
         model_write(s, w, a, d);
      end

      psel = 0; penable = 0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
